// File: rtl/display_scan_driver.sv
// display_scan_driver: deserialises a 48-bit, six-digit 7-segment frame from
// an asynchronous 3-wire serial stream and drives a time-multiplexed 6-digit
// display. Each digit slot starts with a short blank period to stop ghosting.
module display_scan_driver #(
    parameter int SYS_CLK_HZ       = 50_000_000,
    parameter int DIGIT_HZ         = 1_000,
    parameter int BLANK_CYCLES     = 16,
    parameter bit SEG_ACTIVE_LOW   = 1'b0,
    parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_serial_clk,
    input  logic       i_serial_data,
    input  logic       i_serial_latch,
    output logic [7:0] o_segments,
    output logic [5:0] o_digit_sel,
    output logic       o_frame_valid,
    output logic       o_frame_err
);

    localparam int DWELL = SYS_CLK_HZ / DIGIT_HZ;
    localparam int DCW   = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] BLANK_LAST = DCW'(BLANK_CYCLES - 1);
    localparam logic [DCW-1:0] SHOW_LAST  = DCW'(DWELL - BLANK_CYCLES - 1);
    localparam logic [5:0]     CNT_FULL   = 6'd48;
    localparam logic [5:0]     CNT_SAT    = 6'd49;

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    // Synchroniser chains; bit 1 is the synchronised level, bit 2 the delayed copy
    logic [2:0]  sclk_sync;
    logic [1:0]  sdata_sync;
    logic [2:0]  slatch_sync;
    logic        sclk_rise;
    logic        slatch_rise;

    logic [47:0] shift_reg;
    logic [47:0] shift_next;
    logic [5:0]  bit_cnt;
    logic [5:0]  cnt_next;
    logic [47:0] disp_reg;
    logic        frame_valid;
    logic        frame_err;

    state_t         state;
    logic [DCW-1:0] dcnt;
    logic [2:0]     idx;
    logic [7:0]     seg_q;
    logic [5:0]     sel_q;

    // Byte of the frame shown at digit index i (0 = hours MSB)
    function automatic logic [7:0] digit_byte(input logic [47:0] f, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = f[47:40];
            3'd1:    b = f[39:32];
            3'd2:    b = f[31:24];
            3'd3:    b = f[23:16];
            3'd4:    b = f[15:8];
            default: b = f[7:0];
        endcase
        return b;
    endfunction

    // Digit enable for index i; index 0 drives the leftmost position, bit 5
    function automatic logic [5:0] digit_onehot(input logic [2:0] i);
        logic [5:0] s;
        case (i)
            3'd0:    s = 6'b100000;
            3'd1:    s = 6'b010000;
            3'd2:    s = 6'b001000;
            3'd3:    s = 6'b000100;
            3'd4:    s = 6'b000010;
            default: s = 6'b000001;
        endcase
        return s;
    endfunction

    // Bring the asynchronous serial pins into the system clock domain
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sclk_sync   <= '0;
            sdata_sync  <= '0;
            slatch_sync <= '0;
        end else begin
            sclk_sync   <= {sclk_sync[1:0], i_serial_clk};
            sdata_sync  <= {sdata_sync[0], i_serial_data};
            slatch_sync <= {slatch_sync[1:0], i_serial_latch};
        end
    end

    assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
    assign slatch_rise = slatch_sync[1] & ~slatch_sync[2];

    // Shift result of this cycle; a latch in the same cycle sees the new bit
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        if (sclk_rise) begin
            shift_next = {shift_reg[46:0], sdata_sync[1]};
            cnt_next   = (bit_cnt == CNT_SAT) ? CNT_SAT : bit_cnt + 6'd1;
        end
    end

    // Deserialiser and frame commit, independent of the scan enable
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            disp_reg    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            frame_err <= 1'b0;
            if (slatch_rise) begin
                bit_cnt <= '0;
                if (cnt_next == CNT_FULL) begin
                    disp_reg    <= shift_next;
                    frame_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end else begin
                bit_cnt <= cnt_next;
            end
        end
    end

    // Scan FSM: blank period then show period per digit, outputs registered
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= BLANK;
            dcnt  <= '0;
            idx   <= '0;
            seg_q <= '0;
            sel_q <= '0;
        end else if (!i_en) begin
            seg_q <= '0;
            sel_q <= '0;
        end else begin
            case (state)
                BLANK: begin
                    if (dcnt == BLANK_LAST) begin
                        state <= SHOW;
                        dcnt  <= '0;
                        sel_q <= digit_onehot(idx);
                        seg_q <= frame_valid ? digit_byte(disp_reg, idx) : 8'h00;
                    end else begin
                        dcnt  <= dcnt + 1'b1;
                        sel_q <= '0;
                        seg_q <= '0;
                    end
                end
                SHOW: begin
                    if (dcnt == SHOW_LAST) begin
                        state <= BLANK;
                        dcnt  <= '0;
                        idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                        sel_q <= '0;
                        seg_q <= '0;
                    end else begin
                        dcnt  <= dcnt + 1'b1;
                        sel_q <= digit_onehot(idx);
                        seg_q <= frame_valid ? digit_byte(disp_reg, idx) : 8'h00;
                    end
                end
                default: begin
                    state <= BLANK;
                    dcnt  <= '0;
                    sel_q <= '0;
                    seg_q <= '0;
                end
            endcase
        end
    end

    assign o_segments    = seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign o_digit_sel   = sel_q ^ {6{DIGIT_ACTIVE_LOW}};
    assign o_frame_valid = frame_valid;
    assign o_frame_err   = frame_err;

endmodule
